// File: rtl/panel_scan_ctrl.sv
// rtl/panel_scan_ctrl.sv - HUB75 scan controller driving bit-plane shift, latch, oe and row address
// Optional feature macro: PANEL_BRIGHTNESS_EN (adds brightness input that trims each plane's lit time)
module panel_scan_ctrl #(
  parameter int COLUMNS = 32,
  parameter int ROWS    = 8,
  parameter int BITS    = 4,
  parameter int OE_BASE = 8,
  localparam int CW = $clog2(COLUMNS),
  localparam int RW = $clog2(ROWS),
  localparam int PW = (BITS > 1) ? $clog2(BITS) : 1,
  localparam int DW = $clog2(OE_BASE) + BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
`ifdef PANEL_BRIGHTNESS_EN
  input  logic [7:0]          brightness,
`endif
  output logic                fb_rd_en,
  output logic [RW+CW-1:0]    fb_addr,
  input  logic [6*BITS-1:0]   fb_data,
  output logic [5:0]          rgb,
  output logic [RW-1:0]       a,
  output logic                oe,
  output logic                lat,
  output logic                oclk,
  output logic                frame_start
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_SHIFT, S_BLANK, S_LATCH, S_DISPLAY} state_t;

  state_t         state;
  logic [RW-1:0]  row;
  logic [PW-1:0]  plane;
  logic [CW-1:0]  col;
  logic [1:0]     phase;
  logic [DW-1:0]  dcnt;
  logic [DW-1:0]  on_len;
  logic [DW-1:0]  plane_len;
  logic [DW-1:0]  lit_len;
  logic [5:0]     plane_bits;

  assign plane_len = DW'(OE_BASE) << plane;

`ifdef PANEL_BRIGHTNESS_EN
  logic [DW+7:0] lit_prod;
  assign lit_prod = {8'd0, plane_len} * {{DW{1'b0}}, brightness};
  assign lit_len  = lit_prod[DW+7:8];
`else
  assign lit_len  = plane_len;
`endif

  // Field k of fb_data (k=0 is R1, in the MSBs) maps to rgb bit k.
  always_comb begin
    plane_bits = '0;
    for (int k = 0; k < 6; k++)
      plane_bits[k] = fb_data[(5-k)*BITS + int'(plane)];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      row         <= '0;
      plane       <= '0;
      col         <= '0;
      phase       <= '0;
      dcnt        <= '0;
      on_len      <= '0;
      rgb         <= '0;
      a           <= '0;
      oe          <= 1'b1;
      lat         <= 1'b0;
      oclk        <= 1'b0;
      fb_rd_en    <= 1'b0;
      fb_addr     <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      fb_rd_en    <= 1'b0;
      oclk        <= 1'b0;
      lat         <= 1'b0;
      case (state)
        S_IDLE: begin
          oe <= 1'b1;
          if (enable) begin
            frame_start <= 1'b1;
            row         <= '0;
            plane       <= '0;
            state       <= S_START;
          end
        end
        S_START: begin
          fb_rd_en <= 1'b1;
          fb_addr  <= {row, {CW{1'b0}}};
          col      <= '0;
          phase    <= '0;
          state    <= S_SHIFT;
        end
        S_SHIFT: begin
          case (phase)
            2'd0: phase <= 2'd1;
            2'd1: begin
              rgb   <= plane_bits;
              oclk  <= 1'b1;
              phase <= 2'd2;
            end
            default: begin
              phase <= 2'd0;
              if (col == CW'(COLUMNS-1)) begin
                col   <= '0;
                a     <= row;
                state <= S_BLANK;
              end else begin
                col      <= col + CW'(1);
                fb_rd_en <= 1'b1;
                fb_addr  <= {row, col + CW'(1)};
              end
            end
          endcase
        end
        S_BLANK: begin
          lat   <= 1'b1;
          state <= S_LATCH;
        end
        S_LATCH: begin
          // brightness is captured here so the whole DISPLAY uses one value
          on_len <= lit_len;
          oe     <= (lit_len == '0);
          dcnt   <= '0;
          state  <= S_DISPLAY;
        end
        S_DISPLAY: begin
          if (dcnt == plane_len - DW'(1)) begin
            oe <= 1'b1;
            if (plane != PW'(BITS-1)) begin
              plane    <= plane + PW'(1);
              fb_rd_en <= 1'b1;
              fb_addr  <= {row, {CW{1'b0}}};
              state    <= S_SHIFT;
            end else if (row != RW'(ROWS-1)) begin
              plane    <= '0;
              row      <= row + RW'(1);
              fb_rd_en <= 1'b1;
              fb_addr  <= {row + RW'(1), {CW{1'b0}}};
              state    <= S_SHIFT;
            end else begin
              // End of frame doubles as the IDLE enable sample so the period has no gap cycle.
              plane       <= '0;
              row         <= '0;
              frame_start <= enable;
              state       <= enable ? S_START : S_IDLE;
            end
          end else begin
            dcnt <= dcnt + DW'(1);
            oe   <= (dcnt + DW'(1)) >= on_len;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
